// File: rtl/strhw_common_types.sv
// Shared types and constants for the strhw hash datapath (S-box, linear map).
// Latency: n/a (constants, types and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   uint512     - 512-bit operand/result word
//   state_t     - CLEAR / BUSY / DONE status reported to the initiator
//   PI[256]     - byte substitution table
//   A[64]       - linear-map row constants; A[i] pairs with word bit 63-i
//   sbox_512()  - applies PI to all 64 bytes of a 512-bit value
package strhw_common_types;

  typedef logic [511:0] uint512;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam bit ENABLE_DEBUG_OUTPUT = 1'b0;

  localparam logic [7:0] PI [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  localparam logic [63:0] A [64] = '{
    64'h8e20faa72ba0b470, 64'h47107ddd9b505a38, 64'had08b0e0c3282d1c, 64'hd8045870ef14980e,
    64'h6c022c38f90a4c07, 64'h3601161cf205268d, 64'h1b8e0b0e798c13c8, 64'h83478b07b2468764,
    64'ha011d380818e8f40, 64'h5086e740ce47c920, 64'h2843fd2067adea10, 64'h14aff010bdd87508,
    64'h0ad97808d06cb404, 64'h05e23c0468365a02, 64'h8c711e02341b2d01, 64'h46b60f011a83988e,
    64'h90dab52a387ae76f, 64'h486dd4151c3dfdb9, 64'h24b86a840e90f0d2, 64'h125c354207487869,
    64'h092e94218d243cba, 64'h8a174a9ec8121e5d, 64'h4585254f64090fa0, 64'haccc9ca9328a8950,
    64'h9d4df05d5f661451, 64'hc0a878a0a1330aa6, 64'h60543c50de970553, 64'h302a1e286fc58ca7,
    64'h18150f14b9ec46dd, 64'h0c84890ad27623e0, 64'h0642ca05693b9f70, 64'h0321658cba93c138,
    64'h86275df09ce8aaa8, 64'h439da0784e745554, 64'hafc0503c273aa42a, 64'hd960281e9d1d5215,
    64'he230140fc0802984, 64'h71180a8960409a42, 64'hb60c05ca30204d21, 64'h5b068c651810a89e,
    64'h456c34887a3805b9, 64'hac361a443d1c8cd2, 64'h561b0d22900e4669, 64'h2b838811480723ba,
    64'h9bcf4486248d9f5d, 64'hc3e9224312c8c1a0, 64'heffa11af0964ee50, 64'hf97d86d98a327728,
    64'he4fa2054a80b329c, 64'h727d102a548b194e, 64'h39b008152acb8227, 64'h9258048415eb419d,
    64'h492c024284fbaec0, 64'haa16012142f35760, 64'h550b8e9e21f7a530, 64'ha48b474f9ef5dc18,
    64'h70a6a56e2440598e, 64'h3853dc371220a247, 64'h1ca76e95091051ad, 64'h0edd37c48a08a6d8,
    64'h07e095624504536c, 64'h8d70c431ac02a736, 64'hc83862965601dd1b, 64'h641c314b2b8ee083
  };

  // Byte k (bits 8k+7:8k) is replaced by PI[byte]; all 64 bytes in parallel.
  function automatic uint512 sbox_512(input uint512 x);
    uint512 y;
    y = '0;
    for (int k = 0; k < 64; k++) begin
      y[8*k +: 8] = PI[x[8*k +: 8]];
    end
    return y;
  endfunction

endpackage

// File: rtl/strhw_sl_lword.sv
// One 64-bit lane of the linear map l: folds BITS_PER_CYCLE matrix rows per enable.
// Latency: one fold per enabled cycle; acc_nxt is the combinational value after this cycle's fold.
// Backpressure: none; the owning FSM sequences clear/enable/cnt.
//
// Ports:
//   clk_i, rst_i  - clock, async active-high reset
//   clear         - zero the accumulator (takes priority over enable)
//   enable        - fold the rows selected by cnt into the accumulator
//   word          - substituted 64-bit word being multiplied by A
//   cnt           - fold step; rows cnt*BITS_PER_CYCLE .. +BITS_PER_CYCLE-1
//   acc_nxt       - accumulator including the current step's rows
module strhw_sl_lword
  import strhw_common_types::*;
#(
  parameter int BITS_PER_CYCLE = 4,
  parameter int CNT_W          = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear,
  input  logic             enable,
  input  logic [63:0]      word,
  input  logic [CNT_W-1:0] cnt,
  output logic [63:0]      acc_nxt
);

  logic [63:0] acc_q;
  logic [63:0] fold;
  logic [5:0]  row;

  // Row i of A pairs with word bit 63-i (MSB first).
  always_comb begin
    fold = '0;
    row  = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      row = 6'(int'(cnt) * BITS_PER_CYCLE + k);
      if (word[6'd63 - row]) begin
        fold = fold ^ A[row];
      end
    end
  end

  assign acc_nxt = acc_q ^ fold;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (enable) begin
      acc_q <= acc_nxt;
    end
  end

endmodule

// File: rtl/strhw_sl.sv
// SL responder: captures a 512-bit operand on trg_i, applies PI to all bytes, then l to each word.
// Latency: 2 + 64/BITS_PER_CYCLE cycles from the trigger cycle to the ready_o pulse.
// Backpressure: none; triggers while busy are dropped, a trigger in the ready_o cycle is accepted.
//
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - async active-high reset; clears result, status and any in-flight operation
//   trg_i     - one-cycle request; a_i sampled in the same cycle when idle
//   a_i       - 512-bit operand
//   result_o  - SL(a), held until the next accepted trigger completes
//   ready_o   - one-cycle pulse when result_o has just been updated
//   state_o   - CLEAR after reset, BUSY while computing, DONE once a result is held
module strhw_sl
  import strhw_common_types::*;
#(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   trg_i,
  input  uint512 a_i,
  output uint512 result_o,
  output logic   ready_o,
  output state_t state_o
);

  localparam int LIN_CYCLES = 64 / BITS_PER_CYCLE;
  localparam int CNT_W      = (LIN_CYCLES > 1) ? $clog2(LIN_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIN_CYCLES - 1);

  localparam logic [1:0] FSM_IDLE = 2'd0;
  localparam logic [1:0] FSM_SUB  = 2'd1;
  localparam logic [1:0] FSM_LIN  = 2'd2;

  logic [1:0]       fsm_q;
  uint512           data_q;
  logic [CNT_W-1:0] cnt_q;

  logic   lin_clear;
  logic   lin_en;
  logic   lin_last;
  uint512 lin_acc;

  assign lin_clear = (fsm_q == FSM_SUB);
  assign lin_en    = (fsm_q == FSM_LIN);
  assign lin_last  = lin_en && (cnt_q == CNT_LAST);

  // Eight independent lanes share the step counter; word w is bits 64w+63:64w.
  for (genvar w = 0; w < 8; w++) begin : g_lword
    strhw_sl_lword #(
      .BITS_PER_CYCLE (BITS_PER_CYCLE),
      .CNT_W          (CNT_W)
    ) u_lword (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear   (lin_clear),
      .enable  (lin_en),
      .word    (data_q[64*w +: 64]),
      .cnt     (cnt_q),
      .acc_nxt (lin_acc[64*w +: 64])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q    <= FSM_IDLE;
      data_q   <= '0;
      cnt_q    <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
      state_o  <= CLEAR;
    end else begin
      ready_o <= 1'b0;
      case (fsm_q)
        FSM_IDLE: begin
          if (trg_i) begin
            data_q  <= a_i;
            state_o <= BUSY;
            fsm_q   <= FSM_SUB;
          end
        end
        FSM_SUB: begin
          data_q <= sbox_512(data_q);
          cnt_q  <= '0;
          fsm_q  <= FSM_LIN;
        end
        FSM_LIN: begin
          cnt_q <= cnt_q + 1'b1;
          // The last step's rows are not yet in the lane registers, so take acc_nxt.
          if (lin_last) begin
            result_o <= lin_acc;
            ready_o  <= 1'b1;
            state_o  <= DONE;
            fsm_q    <= FSM_IDLE;
          end
        end
        default: begin
          fsm_q <= FSM_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strhw_sl.sv
// Bench for strhw_sl: three instances (BITS_PER_CYCLE 1, 4, 16) share one stimulus stream.
// Latency: expected ready pulse 66 / 18 / 6 cycles after the trigger cycle.
// Backpressure: n/a.
module tb_strhw_sl;
  import strhw_common_types::*;

  localparam int BPC [3] = '{1, 4, 16};
  localparam int LAT [3] = '{66, 18, 6};

  logic   clk_i;
  logic   rst_i;
  logic   trg_i;
  uint512 a_i;
  uint512 res [3];
  logic   rdy [3];
  state_t st  [3];

  int n_chk = 0;
  int n_err = 0;

  for (genvar d = 0; d < 3; d++) begin : g_dut
    strhw_sl #(.BITS_PER_CYCLE(BPC[d])) u_dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .trg_i    (trg_i),
      .a_i      (a_i),
      .result_o (res[d]),
      .ready_o  (rdy[d]),
      .state_o  (st[d])
    );
  end

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] l_model(input logic [63:0] x);
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < 64; i++) begin
      if (x[63-i]) acc = acc ^ A[i];
    end
    return acc;
  endfunction

  function automatic uint512 sl_model(input uint512 a);
    uint512      r;
    logic [63:0] w;
    r = '0;
    for (int wi = 0; wi < 8; wi++) begin
      w = '0;
      for (int b = 0; b < 8; b++) w[8*b +: 8] = PI[a[64*wi + 8*b +: 8]];
      r[64*wi +: 64] = l_model(w);
    end
    return r;
  endfunction

  function automatic uint512 rnd512();
    uint512 r;
    r = '0;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // Pulses trg_i with operand a, optionally re-pulses with a2 during LIN, then watches 80 cycles.
  task automatic run_op(input string tag, input uint512 a, input uint512 exp,
                        input bit glitch, input uint512 a2);
    int lat    [3];
    int pulses [3];
    for (int d = 0; d < 3; d++) begin
      lat[d]    = -1;
      pulses[d] = 0;
    end
    a_i   = a;
    trg_i = 1'b1;
    @(negedge clk_i);
    trg_i = 1'b0;
    a_i   = ~a;
    for (int n = 1; n <= 80; n++) begin
      for (int d = 0; d < 3; d++) begin
        if (rdy[d]) begin
          pulses[d]++;
          if (lat[d] < 0) lat[d] = n;
        end
      end
      if (glitch && n == 2) begin
        trg_i = 1'b1;
        a_i   = a2;
      end else if (glitch && n == 3) begin
        trg_i = 1'b0;
        a_i   = ~a;
      end
      @(negedge clk_i);
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_lat_b%0d", tag, BPC[d]), 512'(lat[d]), 512'(LAT[d]));
      check($sformatf("%s_pulses_b%0d", tag, BPC[d]), 512'(pulses[d]), 512'(1));
      check($sformatf("%s_res_b%0d", tag, BPC[d]), res[d], exp);
      check($sformatf("%s_state_b%0d", tag, BPC[d]), 512'(st[d]), 512'(DONE));
    end
  endtask

  initial begin
    uint512      op1;
    uint512      op2;
    uint512      e1;
    uint512      e2;
    logic [63:0] l_fc;

    rst_i = 1'b1;
    trg_i = 1'b0;
    a_i   = '0;
    repeat (2) @(negedge clk_i);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_res_b%0d", BPC[d]), res[d], '0);
      check($sformatf("rst_rdy_b%0d", BPC[d]), 512'(rdy[d]), 512'(0));
      check($sformatf("rst_state_b%0d", BPC[d]), 512'(st[d]), 512'(CLEAR));
    end
    rst_i = 1'b0;
    @(negedge clk_i);

    // Hand-computed anchors: PI[A5]=00, PI[7B]=80, PI[2D]=01.
    run_op("anc_zero", {64{8'hA5}}, '0, 1'b0, '0);
    run_op("anc_row0", {{56{8'hA5}}, 64'h7BA5A5A5A5A5A5A5},
           {448'h0, 64'h8e20faa72ba0b470}, 1'b0, '0);
    run_op("anc_row63", {{32{8'hA5}}, 64'hA5A5A5A5A5A5A52D, {24{8'hA5}}},
           {256'h0, 64'h641c314b2b8ee083, 192'h0}, 1'b0, '0);
    run_op("anc_row0_63", {64'h7BA5A5A5A5A5A52D, {56{8'hA5}}},
           {64'hea3ccbec002e54f3, 448'h0}, 1'b0, '0);

    l_fc = l_model(64'hfcfcfcfcfcfcfcfc);
    run_op("zero", '0, {8{l_fc}}, 1'b0, '0);
    run_op("byte0_01", 512'h01, {{7{l_fc}}, l_model(64'hfcfcfcfcfcfcfcee)}, 1'b0, '0);

    for (int t = 0; t < 200; t++) begin
      op1 = rnd512();
      run_op($sformatf("rnd%0d", t), op1, sl_model(op1), 1'b0, '0);
    end

    op1 = rnd512();
    op2 = rnd512();
    run_op("glitch", op1, sl_model(op1), 1'b1, op2);

    // Asynchronous reset in the middle of LIN, away from any clock edge.
    a_i   = rnd512();
    trg_i = 1'b1;
    @(negedge clk_i);
    trg_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("arst_res_b%0d", BPC[d]), res[d], '0);
      check($sformatf("arst_rdy_b%0d", BPC[d]), 512'(rdy[d]), 512'(0));
      check($sformatf("arst_state_b%0d", BPC[d]), 512'(st[d]), 512'(CLEAR));
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("arst_hold_b%0d", BPC[d]), res[d], '0);
    end
    run_op("post_rst", '0, {8{l_fc}}, 1'b0, '0);

    // Back-to-back on the BITS_PER_CYCLE=4 instance: retrigger in its ready cycle.
    op1 = rnd512();
    op2 = rnd512();
    e1  = sl_model(op1);
    e2  = sl_model(op2);
    a_i   = op1;
    trg_i = 1'b1;
    @(negedge clk_i);
    trg_i = 1'b0;
    a_i   = op2;
    repeat (16) @(negedge clk_i);
    check("b2b_pre_rdy", 512'(rdy[1]), 512'(0));
    @(negedge clk_i);
    check("b2b_rdy1", 512'(rdy[1]), 512'(1));
    check("b2b_res1", res[1], e1);
    trg_i = 1'b1;
    a_i   = op2;
    @(negedge clk_i);
    trg_i = 1'b0;
    a_i   = '0;
    check("b2b_pulse_end", 512'(rdy[1]), 512'(0));
    check("b2b_state_busy", 512'(st[1]), 512'(BUSY));
    repeat (16) @(negedge clk_i);
    check("b2b_hold_res", res[1], e1);
    check("b2b_hold_rdy", 512'(rdy[1]), 512'(0));
    @(negedge clk_i);
    check("b2b_rdy2", 512'(rdy[1]), 512'(1));
    check("b2b_res2", res[1], e2);
    repeat (70) @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
